product_bcd_converter: RTL and testbench



---
 rtl/product_bcd_converter.sv | 100 ++++++++++
 tb/tb_product_bcd_converter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/product_bcd_converter.sv
// product_bcd_converter
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Captures the multiplier product on start and presents hundreds/tens/ones
// digits that only change when a conversion completes.
module product_bcd_converter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] product,
   output logic             busy,
   output logic             done,
   output logic [3:0]       hundreds,
   output logic [3:0]       tens,
   output logic [3:0]       ones
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_bin;
   logic [11:0]      r_bcd;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [3:0]       r_hundreds;
   logic [3:0]       r_tens;
   logic [3:0]       r_ones;

   logic [11:0]      w_corr;
   logic [11:0]      w_next;

   // Add-3 correction on every scratch digit >= 5, then shift in the binary MSB.
   always_comb begin
      w_corr = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         if (r_bcd[i*4 +: 4] >= 4'd5)
            w_corr[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
         else
            w_corr[i*4 +: 4] = r_bcd[i*4 +: 4];
      end
      // The shifted-out top bit is always zero for legal WIDTH (value <= 999).
      w_next = 12'(w_corr << 1) | {11'b0, r_bin[WIDTH-1]};
   end

   // Conversion FSM with registered status and digit outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_bin      <= '0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_hundreds <= '0;
         r_tens     <= '0;
         r_ones     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_bin   <= product;
                  r_bcd   <= '0;
                  r_cnt   <= CW'(WIDTH);
                  r_busy  <= 1'b1;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               r_bcd <= w_next;
               r_bin <= r_bin << 1;
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_hundreds <= w_next[11:8];
                  r_tens     <= w_next[7:4];
                  r_ones     <= w_next[3:0];
                  r_done     <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign hundreds = r_hundreds;
   assign tens     = r_tens;
   assign ones     = r_ones;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter (WIDTH = 8).
module tb_product_bcd_converter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] product = '0;
   logic       busy;
   logic       done;
   logic [3:0] hundreds;
   logic [3:0] tens;
   logic [3:0] ones;

   int vectors = 0;
   int miscompares = 0;

   product_bcd_converter #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .product  (product),
      .busy     (busy),
      .done     (done),
      .hundreds (hundreds),
      .tens     (tens),
      .ones     (ones)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] p;
      int         h;
      int         t;
      int         o;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: decimal digits by plain arithmetic.
   function automatic int ref_digits(input int v);
      return (v / 100) * 100 + ((v / 10) % 10) * 10 + (v % 10);
   endfunction

   function automatic int dut_digits();
      return int'(hundreds) * 100 + int'(tens) * 10 + int'(ones);
   endfunction

   // Pulse start with p, wait (bounded) for done; check latency, result, hold behaviour.
   task automatic run_conv(input logic [7:0] p, input string name);
      int lat;
      int prev;
      bit held_ok;
      bit bd_ok;
      prev    = dut_digits();
      held_ok = 1'b1;
      bd_ok   = 1'b1;
      @(negedge clk);
      start   = 1'b1;
      product = p;
      @(negedge clk);
      start   = 1'b0;
      lat = 0;
      if (!busy) bd_ok = 1'b0;
      while (!done && lat < 20) begin
         if (dut_digits() != prev) held_ok = 1'b0;
         if (busy && done) bd_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      chk({name, " latency"}, lat, 8);
      chk({name, " digits"}, dut_digits(), ref_digits(int'(p)));
      chk({name, " held"}, int'(held_ok), 1);
      chk({name, " busy/done"}, int'(bd_ok && !busy), 1);
      @(negedge clk);
      chk({name, " done width"}, int'(done), 0);
   endtask

   vec_t tbl[$];
   logic [7:0] sweep[$];

   initial begin
      int cyc;
      int last;
      int k;
      int seen;

      // Reset
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset digits", dut_digits(), 0);

      tbl = '{
         '{p: 8'd0,   h: 0, t: 0, o: 0},
         '{p: 8'd225, h: 2, t: 2, o: 5},
         '{p: 8'd99,  h: 0, t: 9, o: 9},
         '{p: 8'd100, h: 1, t: 0, o: 0},
         '{p: 8'd255, h: 2, t: 5, o: 5},
         '{p: 8'd5,   h: 0, t: 0, o: 5},
         '{p: 8'd50,  h: 0, t: 5, o: 0},
         '{p: 8'd128, h: 1, t: 2, o: 8},
         '{p: 8'd199, h: 1, t: 9, o: 9},
         '{p: 8'd250, h: 2, t: 5, o: 0}
      };
      foreach (tbl[i]) begin
         run_conv(tbl[i].p, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d table", i), dut_digits(),
             tbl[i].h * 100 + tbl[i].t * 10 + tbl[i].o);
      end

      // Ignored product change and start during SHIFT
      @(negedge clk);
      start = 1'b1; product = 8'd42;
      @(negedge clk);
      start = 1'b0; product = 8'd200;
      seen = 0;
      for (int c = 1; c <= 25; c++) begin
         if (c == 3) start = 1'b1;
         if (c == 4) start = 1'b0;
         @(negedge clk);
         if (done) begin
            seen++;
            chk("ignore digits", dut_digits(), 42);
         end
      end
      chk("ignore done count", seen, 1);
      chk("ignore idle", int'(busy), 0);

      // Reset mid-conversion
      @(negedge clk);
      start = 1'b1; product = 8'd225;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         if (done) seen++;
         @(negedge clk);
      end
      chk("abort done", seen, 0);
      chk("abort busy", int'(busy), 0);
      chk("abort digits", dut_digits(), 0);
      run_conv(8'd7, "after abort");

      // Randomized products
      for (int i = 0; i < 30; i++)
         run_conv(8'($urandom_range(0, 255)), $sformatf("rand%0d", i));

      // Exhaustive 4x4 multiplier sweep with start held high
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            sweep.push_back(8'(a * b));
      @(negedge clk);
      start = 1'b1;
      product = sweep[0];
      k = 0; cyc = 0; last = 0;
      while (k < 256 && cyc < 256 * 9 + 40) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            chk($sformatf("sweep%0d", k), dut_digits(), ref_digits(int'(sweep[k])));
            if (busy) chk("sweep busy&done", 1, 0);
            if (k > 0) chk($sformatf("sweep%0d spacing", k), cyc - last, 9);
            last = cyc;
            k++;
            if (k < 256) product = sweep[k];
            else start = 1'b0;
         end
      end
      start = 1'b0;
      chk("sweep count", k, 256);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
